imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter WIDTH, default 32: immediate width.
REQ-002 Parameter INSTR_WIDTH, default 32: instruction width.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 In_Valid  input  1: request valid.
REQ-006 In_Ready  output  1: request accepted when In_Valid && In_Ready at a clk edge.
REQ-007 ImmediateSrc  input  3: format select (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE from CPU_Control_Codes.vh).
REQ-008 Immediate  input  WIDTH: sign-extended byte-offset immediate, same value convention as Imm_Gen output.
REQ-009 Base_Instr  input  INSTR_WIDTH: instruction template (opcode, rd, rs1, rs2, funct3, funct7); bits at the format's immediate positions are ignored.
REQ-010 Out_Valid  output  1: Instr_RV32IM/Imm_Err valid.
REQ-011 Out_Ready  input  1: consumer accepts when Out_Valid && Out_Ready at a clk edge.
REQ-012 Instr_RV32IM  output  INSTR_WIDTH: encoded instruction.
REQ-013 Imm_Err  output  1: immediate not representable in the selected format.
REQ-014 Err_Count  output  8: saturating count of accepted requests with Imm_Err=1.

Function
REQ-015 Encoding SHALL be the exact inverse of Imm_Gen: Imm_Gen(Instr_RV32IM, ImmediateSrc) == Immediate whenever Imm_Err=0.
REQ-016 I: [31:20]=imm[11:0]; S: [31:25]=imm[11:5], [11:7]=imm[4:0]; B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; U: [31:12]=imm[31:12]; J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; all other bits from Base_Instr.
REQ-017 IMM_NONE: Instr_RV32IM = Base_Instr unchanged, Imm_Err=0, Immediate ignored.
REQ-018 Imm_Err=1 when: I/S and imm[31:11] not all equal; B and (imm[31:12] not all equal or imm[0]=1); J and (imm[31:20] not all equal or imm[0]=1); U and imm[11:0]!=0; ImmediateSrc an undefined code.
REQ-019 On Imm_Err=1 the instruction SHALL still be formed per REQ-016 (truncated fields, dropped bit0); undefined code yields Base_Instr unchanged.
REQ-020 Encoding computed combinationally on acceptance and stored in a 2-entry in-order FIFO; latency 1 cycle (accepted at edge N, Out_Valid=1 after edge N when FIFO was empty).
REQ-021 In_Ready = (occupancy < 2); depends only on registered state, never combinationally on Out_Ready.
REQ-022 Out_Valid = (occupancy > 0); Instr_RV32IM/Imm_Err = head entry, held stable while Out_Valid && !Out_Ready.
REQ-023 Simultaneous push and pop at occupancy 1: occupancy stays 1, head becomes new entry; at occupancy 2 no push occurs.
REQ-024 Pop at occupancy 0 and push at occupancy 2 SHALL have no effect.
REQ-025 FIFO pointers wrap modulo 2; output order equals acceptance order.
REQ-026 Err_Count increments on acceptance of a request with Imm_Err=1; holds at 8'hFF.
REQ-027 Outputs with Out_Valid=0: Instr_RV32IM=0, Imm_Err=0.

Reset
REQ-028 While rst=1 at an edge: occupancy=0, pointers=0, Err_Count=0, Out_Valid=0, Instr_RV32IM=0, Imm_Err=0; In_Ready=1 after the edge.
REQ-029 Reset mid-operation SHALL discard all buffered entries; any request presented during the reset edge is not accepted.

Verification
REQ-030 IMM_I, Base 0x00008113, Imm 0x00000005 -> next cycle Instr 0x00508113, Imm_Err=0.
REQ-031 IMM_B, Base 0x00208063, Imm 0x00000002 -> Instr 0x00208163, Imm_Err=0; Imm 0x00000003 -> Instr 0x00208163, Imm_Err=1, Err_Count+1.
REQ-032 IMM_J, Base 0x0000026F, Imm 0xFFF007F6 -> Instr 0xFF60026F, Imm_Err=0; IMM_U Imm 0x12345001, Base 0x00000137 -> Instr 0x12345137, Imm_Err=1.
REQ-033 Out_Ready=0, three back-to-back requests -> first two accepted, In_Ready=0 on third until one pop; outputs emerge in order, each held stable while stalled.
REQ-034 Occupancy 1, push and pop same cycle for 10 cycles -> Out_Valid stays 1, one output per cycle, no loss/duplication.
REQ-035 Two entries buffered, Err_Count=5, rst=1 one cycle -> Out_Valid=0, Err_Count=0, In_Ready=1; 300 error requests -> Err_Count=255.

Source files
------------

// File: rtl/imm_encoder.sv
// RV32 immediate encoder: folds a byte-offset immediate into an instruction template
// (inverse of Imm_Gen), with a 2-entry in-order output FIFO and saturating error counter.
module imm_encoder #(
    parameter int WIDTH       = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic [2:0]             ImmediateSrc,
    input  logic [WIDTH-1:0]       Immediate,
    input  logic [INSTR_WIDTH-1:0] Base_Instr,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [INSTR_WIDTH-1:0] Instr_RV32IM,
    output logic                   Imm_Err,
    output logic [7:0]             Err_Count
);

    // Format codes shared with CPU_Control_Codes; 6 and 7 are undefined.
    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_src_e;

    imm_src_e               src;
    logic [INSTR_WIDTH-1:0] enc_instr;
    logic                   enc_err;

    logic [INSTR_WIDTH-1:0] mem_instr [2];
    logic                   mem_err   [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic                   push;
    logic                   pop;

    // True when bits [WIDTH-1:lsb] are not a pure sign extension.
    function automatic logic not_sext(input logic [WIDTH-1:0] v, input int unsigned lsb);
        logic [WIDTH-1:0] s;
        s = WIDTH'($signed(v) >>> lsb);
        return !((s == '0) || (s == '1));
    endfunction

    assign src = imm_src_e'(ImmediateSrc);

    always_comb begin
        enc_instr = Base_Instr;
        enc_err   = 1'b0;
        case (src)
            IMM_I: begin
                enc_instr[31:20] = Immediate[11:0];
                enc_err          = not_sext(Immediate, 11);
            end
            IMM_S: begin
                enc_instr[31:25] = Immediate[11:5];
                enc_instr[11:7]  = Immediate[4:0];
                enc_err          = not_sext(Immediate, 11);
            end
            IMM_B: begin
                enc_instr[31]    = Immediate[12];
                enc_instr[30:25] = Immediate[10:5];
                enc_instr[11:8]  = Immediate[4:1];
                enc_instr[7]     = Immediate[11];
                enc_err          = not_sext(Immediate, 12) | Immediate[0];
            end
            IMM_U: begin
                enc_instr[31:12] = Immediate[31:12];
                enc_err          = |Immediate[11:0];
            end
            IMM_J: begin
                enc_instr[31]    = Immediate[20];
                enc_instr[30:21] = Immediate[10:1];
                enc_instr[20]    = Immediate[11];
                enc_instr[19:12] = Immediate[19:12];
                enc_err          = not_sext(Immediate, 20) | Immediate[0];
            end
            IMM_NONE: ;
            default: enc_err = 1'b1;
        endcase
    end

    assign In_Ready  = (count != 2'd2);
    assign Out_Valid = (count != 2'd0);
    assign push      = In_Valid && In_Ready;
    assign pop       = Out_Valid && Out_Ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            Err_Count <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem_instr[i] <= '0;
                mem_err[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= enc_instr;
                mem_err[wr_ptr]   <= enc_err;
                wr_ptr            <= ~wr_ptr;
                if (enc_err && (Err_Count != 8'hFF))
                    Err_Count <= Err_Count + 8'd1;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign Instr_RV32IM = Out_Valid ? mem_instr[rd_ptr] : '0;
    assign Imm_Err      = Out_Valid ? mem_err[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed steps with a scoreboard queue of
// expected outputs, an occupancy model and a saturating error-count model.
module tb_imm_encoder;

    localparam logic [2:0] C_I = 3'd0, C_S = 3'd1, C_B = 3'd2, C_U = 3'd3,
                           C_J = 3'd4, C_NONE = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        In_Valid;
    logic        In_Ready;
    logic [2:0]  ImmediateSrc;
    logic [31:0] Immediate;
    logic [31:0] Base_Instr;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Instr_RV32IM;
    logic        Imm_Err;
    logic [7:0]  Err_Count;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    imm_encoder #(.WIDTH(32), .INSTR_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .ImmediateSrc (ImmediateSrc),
        .Immediate    (Immediate),
        .Base_Instr   (Base_Instr),
        .Out_Valid    (Out_Valid),
        .Out_Ready    (Out_Ready),
        .Instr_RV32IM (Instr_RV32IM),
        .Imm_Err      (Imm_Err),
        .Err_Count    (Err_Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder written from the field table, using signed range checks.
    function automatic exp_t ref_enc(input logic [2:0] s, input logic [31:0] imm,
                                     input logic [31:0] base);
        exp_t r;
        int   v;
        v       = $signed(imm);
        r.instr = base;
        r.err   = 1'b0;
        case (s)
            C_I: begin
                r.instr = {imm[11:0], base[19:0]};
                r.err   = (v < -2048) || (v > 2047);
            end
            C_S: begin
                r.instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
                r.err   = (v < -2048) || (v > 2047);
            end
            C_B: begin
                r.instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
                r.err   = (v < -4096) || (v > 4095) || imm[0];
            end
            C_U: begin
                r.instr = {imm[31:12], base[11:0]};
                r.err   = (imm[11:0] != 12'h000);
            end
            C_J: begin
                r.instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
                r.err   = (v < -1048576) || (v > 1048575) || imm[0];
            end
            C_NONE: ;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // One clock: check outputs against the model, update scoreboard, advance to next negedge.
    task automatic step();
        logic do_push, do_pop;
        exp_t e;
        int   occ;
        if (!rst) begin
            occ = q.size();
            chk("in_ready", 64'(In_Ready), 64'(occ < 2));
            chk("out_valid", 64'(Out_Valid), 64'(occ > 0));
            if (occ > 0) begin
                chk("instr", 64'(Instr_RV32IM), 64'(q[0].instr));
                chk("imm_err", 64'(Imm_Err), 64'(q[0].err));
            end else begin
                chk("instr_idle", 64'(Instr_RV32IM), 64'h0);
                chk("err_idle", 64'(Imm_Err), 64'h0);
            end
            chk("err_count", 64'(Err_Count), 64'(exp_cnt));
            do_pop  = Out_Ready && (occ > 0);
            do_push = In_Valid && (occ < 2);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e = ref_enc(ImmediateSrc, Immediate, Base_Instr);
                q.push_back(e);
                if (e.err && exp_cnt < 255) exp_cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (rst) begin
            q.delete();
            exp_cnt = 0;
        end
    endtask

    task automatic req(input logic [2:0] s, input logic [31:0] imm, input logic [31:0] base);
        In_Valid     = 1'b1;
        ImmediateSrc = s;
        Immediate    = imm;
        Base_Instr   = base;
    endtask

    task automatic idle();
        In_Valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        idle();
        Out_Ready = 1'b1;
        for (int i = 0; i < max_cycles && q.size() > 0; i++) step();
        chk("drain_done", 64'(q.size()), 64'h0);
    endtask

    initial begin
        rst = 1'b1; In_Valid = 1'b1; Out_Ready = 1'b1;
        ImmediateSrc = C_I; Immediate = 32'h5; Base_Instr = 32'h00008113;
        step(); step();
        rst = 1'b0; idle();
        chk("rst_out_valid", 64'(Out_Valid), 64'h0);
        chk("rst_in_ready", 64'(In_Ready), 64'h1);
        chk("rst_err_count", 64'(Err_Count), 64'h0);
        chk("rst_instr", 64'(Instr_RV32IM), 64'h0);
        step();

        // Directed encodings, one per cycle with consumer always ready
        req(C_I, 32'h00000005, 32'h00008113); step();
        idle();
        chk("i_valid_latency", 64'(Out_Valid), 64'h1);
        chk("i_instr_literal", 64'(Instr_RV32IM), 64'h00508113);
        step();
        req(C_B, 32'h00000002, 32'h00208063); step();
        chk("b_instr_literal", 64'(Instr_RV32IM), 64'h00208163);
        req(C_B, 32'h00000003, 32'h00208063); step();
        chk("b_odd_instr", 64'(Instr_RV32IM), 64'h00208163);
        chk("b_odd_err", 64'(Imm_Err), 64'h1);
        req(C_J, 32'hFFF007F6, 32'h0000026F); step();
        chk("j_instr_literal", 64'(Instr_RV32IM), 64'hFF60026F);
        chk("err_count_b", 64'(Err_Count), 64'h1);
        req(C_U, 32'h12345001, 32'h00000137); step();
        chk("u_instr_literal", 64'(Instr_RV32IM), 64'h12345137);
        chk("u_err", 64'(Imm_Err), 64'h1);
        req(C_S, 32'hFFFFF800, 32'h00112023); step();
        req(C_S, 32'h00000800, 32'h00112023); step();
        req(C_I, 32'hFFFFF7FF, 32'h00008113); step();
        req(C_B, 32'hFFFFF000, 32'h00208063); step();
        req(C_B, 32'h00001000, 32'h00208063); step();
        req(C_J, 32'h000FFFFE, 32'h0000006F); step();
        req(C_J, 32'h00100000, 32'h0000006F); step();
        req(C_NONE, 32'hDEADBEEF, 32'hCAFEF00D); step();
        req(3'd6, 32'h00000004, 32'h01234567); step();
        req(3'd7, 32'h00000000, 32'h89ABCDEF); step();
        drain(5);

        // Stall: three back-to-back requests with consumer blocked
        Out_Ready = 1'b0;
        req(C_I, 32'h00000001, 32'h00000013); step();
        req(C_I, 32'h00000002, 32'h00000093); step();
        req(C_I, 32'h00000003, 32'h00000113); step();
        chk("stall_in_ready", 64'(In_Ready), 64'h0);
        step(); step();
        Out_Ready = 1'b1; step();
        Out_Ready = 1'b0; step();
        drain(6);

        // Streaming at occupancy 1: push and pop every cycle
        Out_Ready = 1'b0;
        req(C_S, 32'h00000010, 32'h00A12023); step();
        Out_Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req(C_I, 32'(i * 7 - 20), 32'h00000013 | 32'(i << 7));
            step();
            chk("stream_valid", 64'(Out_Valid), 64'h1);
        end
        drain(5);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            In_Valid     = ($urandom_range(0, 3) != 0);
            Out_Ready    = ($urandom_range(0, 2) != 0);
            ImmediateSrc = 3'($urandom_range(0, 7));
            Immediate    = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($signed(12'($urandom())));
            Base_Instr   = $urandom();
            step();
        end
        drain(5);

        // Reset with two entries buffered and a count of five
        rst = 1'b1; idle(); step();
        rst = 1'b0; Out_Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req(C_B, 32'h00000001, 32'h00000063); step();
        end
        drain(5);
        Out_Ready = 1'b0;
        req(C_I, 32'h00000007, 32'h00000013); step();
        req(C_I, 32'h00000008, 32'h00000013); step();
        chk("pre_rst_count", 64'(Err_Count), 64'h5);
        chk("pre_rst_full", 64'(In_Ready), 64'h0);
        rst = 1'b1; req(C_B, 32'h00000001, 32'h00000063); step();
        rst = 1'b0; idle();
        chk("mid_rst_valid", 64'(Out_Valid), 64'h0);
        chk("mid_rst_count", 64'(Err_Count), 64'h0);
        chk("mid_rst_ready", 64'(In_Ready), 64'h1);
        step();

        // Saturation of the error counter
        Out_Ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            req(3'd6, 32'(i), 32'h00000013); step();
        end
        drain(5);
        chk("err_count_sat", 64'(Err_Count), 64'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
